// File: rtl/serv_pc_trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serv_pc_trace_pkg
//  Description : Shared packet type codes and field widths for the PC trace
//                compressor and its FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
package serv_pc_trace_pkg;

  localparam int TYPE_W = 2;
  localparam int ADDR_W = 32;

  // Packet type codes carried on o_pkt_type
  typedef enum logic [TYPE_W-1:0] {
    PKT_START = 2'd0,
    PKT_JUMP  = 2'd1,
    PKT_SEQ   = 2'd2,
    PKT_OVF   = 2'd3
  } pkt_type_e;

  // Packed packet layout is {type, count, addr}, MSB first
  function automatic int pkt_width(input int cnt_w);
    return TYPE_W + cnt_w + ADDR_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serv_trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : serv_trace_fifo
//  Description : Synchronous first-word-fall-through FIFO. Pointers carry one
//                extra wrap bit so full and empty are told apart without a
//                separate counter. Head data reads as zero while empty.
//  Revision    : 1.0  initial release
// ============================================================================
module serv_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 50
) (
  input  logic         wb_clk,
  input  logic         wb_rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A push into a full FIFO is refused even if a pop happens the same cycle
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer registers, cleared by reset so the queue empties in one cycle
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset because empty masks the head
  always_ff @(posedge wb_clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/serv_pc_trace.sv
`default_nettype none
// ============================================================================
//  Module      : serv_pc_trace
//  Description : Compresses the instruction-fetch address stream into
//                discontinuity packets (run length + new target), queues them
//                in a small FIFO and reports lost packets with OVF packets.
//  Revision    : 1.0  initial release
// ============================================================================
module serv_pc_trace
  import serv_pc_trace_pkg::*;
#(
  parameter int PC_STEP = 4,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic             i_en,
  input  logic [31:0]      i_pc_adr,
  input  logic             i_pc_vld,
  output logic             o_pkt_valid,
  input  logic             i_pkt_ready,
  output logic [1:0]       o_pkt_type,
  output logic [CNT_W-1:0] o_pkt_count,
  output logic [31:0]      o_pkt_addr,
  output logic             o_ovf
);

  localparam int PKT_W = pkt_width(CNT_W);

  // Tracker state
  logic             started_q, started_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [31:0]      last_pc_q, last_pc_d;

  // Overflow state
  logic             ovf_pending_q, ovf_pending_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [31:0]      ovf_addr_q, ovf_addr_d;
  logic             ovf_q, ovf_d;

  // Event decode
  logic             evt;
  logic             seq_hit;
  logic [CNT_W-1:0] run_inc;
  logic             emit;
  pkt_type_e        emit_type;
  logic [CNT_W-1:0] emit_cnt;

  // Drop / flush
  logic             drop;
  logic             flush;
  logic [CNT_W-1:0] drop_cnt_eff;
  logic [31:0]      ovf_addr_eff;

  // FIFO interface
  logic             fifo_push;
  logic [PKT_W-1:0] fifo_wdata;
  logic [PKT_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;

  assign evt     = i_en & i_pc_vld;
  assign seq_hit = (i_pc_adr == last_pc_q + 32'(PC_STEP));
  assign run_inc = run_q + CNT_W'(1);

  // Classify the fetch and advance run/last_pc as if the emit always lands
  always_comb begin
    started_d = started_q;
    run_d     = run_q;
    last_pc_d = last_pc_q;
    emit      = 1'b0;
    emit_type = PKT_JUMP;
    emit_cnt  = '0;
    if (evt) begin
      last_pc_d = i_pc_adr;
      if (!started_q) begin
        emit      = 1'b1;
        emit_type = PKT_START;
        started_d = 1'b1;
        run_d     = '0;
      end else if (seq_hit) begin
        if (run_inc == '1) begin
          emit      = 1'b1;
          emit_type = PKT_SEQ;
          emit_cnt  = '1;
          run_d     = '0;
        end else begin
          run_d = run_inc;
        end
      end else begin
        emit      = 1'b1;
        emit_type = PKT_JUMP;
        emit_cnt  = run_q;
        run_d     = '0;
      end
    end
  end

  // Once anything is pending, later events must also drop so order is kept
  assign drop         = emit & (fifo_full | ovf_pending_q);
  assign drop_cnt_eff = (drop && (drop_cnt_q != '1)) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;
  assign ovf_addr_eff = drop ? i_pc_adr : ovf_addr_q;
  assign flush        = ovf_pending_q & ~fifo_full;

  // Choose the single FIFO write of the cycle and update overflow bookkeeping
  always_comb begin
    fifo_push     = 1'b0;
    fifo_wdata    = {emit_type, emit_cnt, i_pc_adr};
    drop_cnt_d    = drop_cnt_eff;
    ovf_addr_d    = ovf_addr_eff;
    ovf_pending_d = ovf_pending_q | drop;
    ovf_d         = ovf_q | drop;
    if (flush) begin
      fifo_push     = 1'b1;
      fifo_wdata    = {PKT_OVF, drop_cnt_eff, ovf_addr_eff};
      drop_cnt_d    = '0;
      ovf_pending_d = 1'b0;
    end else if (emit && !drop) begin
      fifo_push = 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      started_q     <= 1'b0;
      run_q         <= '0;
      last_pc_q     <= '0;
      ovf_pending_q <= 1'b0;
      drop_cnt_q    <= '0;
      ovf_addr_q    <= '0;
      ovf_q         <= 1'b0;
    end else begin
      started_q     <= started_d;
      run_q         <= run_d;
      last_pc_q     <= last_pc_d;
      ovf_pending_q <= ovf_pending_d;
      drop_cnt_q    <= drop_cnt_d;
      ovf_addr_q    <= ovf_addr_d;
      ovf_q         <= ovf_d;
    end
  end

  assign fifo_pop = ~fifo_empty & i_pkt_ready;

  serv_trace_fifo #(
    .DEPTH (DEPTH),
    .W     (PKT_W)
  ) u_fifo (
    .wb_clk  (wb_clk),
    .wb_rst  (wb_rst),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign o_pkt_valid = ~fifo_empty;
  assign o_pkt_type  = fifo_head[PKT_W-1 -: TYPE_W];
  assign o_pkt_count = fifo_head[ADDR_W +: CNT_W];
  assign o_pkt_addr  = fifo_head[ADDR_W-1:0];
  assign o_ovf       = ovf_q;

endmodule
`default_nettype wire

// File: doc/serv_pc_trace.md
Name: serv_pc_trace

Overview:
- Downstream trace consumer for the servant simulation harness.
- Watches the instruction-fetch address stream (fetch address plus fetch-acknowledge strobe) and compresses it into discontinuity packets: run length of sequential fetches plus new target.
- Packets are buffered in a small FIFO and drained over a valid/ready port to a bench logger or a UART dumper.
- Loss under backpressure is reported explicitly with overflow packets.

Parameters:
- PC_STEP, 4, byte increment treated as sequential (2 for compressed builds).
- DEPTH, 8, FIFO entries; power of two, ≥2.
- CNT_W, 16, run-length counter / packet count width.

Ports:
- wb_clk  in  1  clock
- wb_rst  in  1  synchronous reset, active high
- i_en  in  1  tracing enable; when low, fetches are ignored and state is held
- i_pc_adr  in  32  fetch address
- i_pc_vld  in  1  fetch acknowledged this cycle; i_pc_adr is valid
- o_pkt_valid  out  1  head packet available
- i_pkt_ready  in  1  consumer accepts head packet
- o_pkt_type  out  2  packet type
- o_pkt_count  out  CNT_W  run length or drop count
- o_pkt_addr  out  32  target or last address
- o_ovf  out  1  sticky: any packet ever dropped since reset

Behaviour:
- Reset: all outputs 0; FIFO empty; started=0; run=0; ovf_pending=0; drop_cnt=0; last_pc=0.
- Types (shared constants): START=0, JUMP=1, SEQ=2, OVF=3.
- Event evaluation occurs only when i_en & i_pc_vld. At most one FIFO write per cycle.
- First fetch after reset (started=0):
  - Emit START{count=0, addr=pc}.
  - Set started=1, last_pc=pc, run=0.
- Sequential fetch (pc == last_pc + PC_STEP, 32-bit wrap allowed):
  - run++.
  - If run reaches 2^CNT_W-1 after the increment, emit SEQ{count=all ones, addr=pc} and clear run to 0.
- Any other address, including pc == last_pc:
  - Emit JUMP{count=run, addr=pc}.
  - Clear run to 0.
- In all event cases, last_pc ← pc.
- Internal state (last_pc, run) always updates as if the emit succeeded, even when the packet is dropped.
- Drop rule: an emit is dropped when the FIFO is full at the start of the cycle, or when ovf_pending=1. A pop in the same cycle does not rescue a push into a full FIFO.
- On drop:
  - drop_cnt++ (saturating at all ones).
  - ovf_pending ← 1; o_ovf ← 1.
  - ovf_addr ← pc.
- OVF flush: in any cycle where ovf_pending=1 and the FIFO is not full:
  - Write OVF{count=drop_cnt', addr=ovf_addr'}.
  - drop_cnt' and ovf_addr' include a same-cycle dropped event.
  - Then clear drop_cnt and ovf_pending.
  - Consequence: packets never reorder, and every lost event is counted in exactly one OVF.
- FIFO behaviour:
  - First-word fall-through; o_pkt_* reflect the head entry.
  - Pop on o_pkt_valid & i_pkt_ready.
  - Push→visible latency is 1 cycle (a packet written in cycle N is visible in N+1).
  - Simultaneous push and pop when not full: occupancy unchanged.
  - Pop when empty is ignored.
- i_en low: fetches are not evaluated; run, last_pc and started are held; the FIFO keeps draining.
- Reset mid-operation: synchronous reset clears everything in one cycle, including queued packets and o_ovf. The next fetch produces START.

Decomposition:
- Shared Verilog include header: packet type localparams (START, JUMP, SEQ, OVF) and the packet field layout (type, count, addr = 34+CNT_W bits).
- Sub-module serv_trace_fifo:
  - Parameters DEPTH and W.
  - Synchronous FWFT FIFO with full/empty flags and ptr+1-bit occupancy.
  - Same clock and reset convention as the parent.
- Top holds the run/last_pc/overflow state logic.

Test Plan:
- Reset; fetches 0x0,0x4,0x8,0xC, jump to 0x100; ready=1 → START{0,0x0}, then JUMP{3,0x100}; no other packets.
- Repeat address: fetch 0x40 then 0x40 → JUMP{0,0x40} after START{0,0x40}.
- Run saturation, CNT_W=4: START at 0x0, then 15 sequential fetches → SEQ{15,0x3C}. Next jump to 0x200 → JUMP{0,0x200}.
- Backpressure, DEPTH=2, ready=0: START plus 4 jumps; FIFO holds START and first JUMP. Raise ready → after the 2 queued packets comes OVF{3, addr of last jump}; o_ovf=1 and stays 1.
- Simultaneous event on OVF flush cycle: ovf_pending with drop_cnt=2; free one slot while a jump occurs → OVF{3,jump addr}; the jump is not separately emitted; the next jump emits normally.
- Reset mid-stream with 3 queued packets → o_pkt_valid=0 next cycle, o_ovf=0; next fetch 0x80 → START{0,0x80}.
